// File: rtl/ex1_1_result_fifo.sv
// Result FIFO behind the a*b+c MAC stage: buffers results, hands them to a
// valid/ready consumer, and records results lost to back-pressure.
module ex1_1_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       validi,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       valido,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          data_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  occ_e              occ;
  logic              push, pop, drop;

  // NOTE: always_comb assigns a default first so no path leaves occ unassigned (no latch).
  always_comb begin
    occ = PARTIAL;
    if (count == '0)           occ = EMPTY;
    else if (count == FULL_CNT) occ = FULL;
  end

  // Outputs come from registered state only; out_ready never reaches them.
  assign valido   = (occ != EMPTY);
  assign data_out = valido ? mem[rd_ptr] : '0;

  assign pop  = valido & out_ready;
  assign push = validi & ((occ != FULL) | pop);
  assign drop = validi & (occ == FULL) & ~pop;

  // NOTE: storage has no reset; count gates visibility, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by natural overflow.
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex1_1_result_fifo.sv
// Directed self-checking bench for ex1_1_result_fifo; a second instance with
// DROP_W=2 exercises drop-counter saturation.
module tb_ex1_1_result_fifo;

  logic        clk = 1'b0;
  logic        rst, validi, out_ready;
  logic [31:0] data_in;
  logic        valido, overflow;
  logic [31:0] data_out;
  logic [2:0]  count;
  logic [7:0]  drop_cnt;

  logic        s_valido, s_overflow;
  logic [31:0] s_data_out;
  logic [2:0]  s_count;
  logic [1:0]  s_drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ex1_1_result_fifo #(.DATA_W(32), .DEPTH(4), .DROP_W(8)) dut (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in),
    .valido(valido), .out_ready(out_ready), .data_out(data_out),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  ex1_1_result_fifo #(.DATA_W(32), .DEPTH(4), .DROP_W(2)) sat (
    .clk(clk), .rst(rst), .validi(validi), .data_in(data_in),
    .valido(s_valido), .out_ready(out_ready), .data_out(s_data_out),
    .count(s_count), .overflow(s_overflow), .drop_cnt(s_drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; validi = 1'b0; out_ready = 1'b0; data_in = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; validi = 1'b1; data_in = 32'hDEAD; out_ready = 1'b0;
    tick();
    tick();
    total_cnt++; if (valido !== 1'b0) $display("FAIL reset_valido got %0b exp 0", valido); else pass_cnt++;
    total_cnt++; if (data_out !== 32'd0) $display("FAIL reset_data got %0h exp 0", data_out); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b exp 0", overflow); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); else pass_cnt++;
    rst = 1'b0; validi = 1'b0;
    tick();
    total_cnt++; if (valido !== 1'b0) $display("FAIL reset_release_valido got %0b exp 0", valido); else pass_cnt++;
  endtask

  task automatic test_latency_order();
    logic [31:0] words [3] = '{32'd7, 32'd11, 32'd13};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      validi = 1'b1; data_in = words[i];
      tick();
      if (i == 0) begin
        total_cnt++; if (valido !== 1'b1) $display("FAIL lat_valido got %0b exp 1", valido); else pass_cnt++;
        total_cnt++; if (data_out !== 32'd7) $display("FAIL lat_head got %0d exp 7", data_out); else pass_cnt++;
      end
    end
    validi = 1'b0;
    total_cnt++; if (count !== 3'd3) $display("FAIL lat_count got %0d exp 3", count); else pass_cnt++;
    tick();
    total_cnt++; if (data_out !== 32'd7) $display("FAIL lat_head_hold got %0d exp 7", data_out); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (valido !== 1'b1 || data_out !== words[i])
        $display("FAIL order_%0d got v=%0b d=%0d exp v=1 d=%0d", i, valido, data_out, words[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if (valido !== 1'b0 || data_out !== 32'd0)
      $display("FAIL order_empty got v=%0b d=%0d exp v=0 d=0", valido, data_out);
    else pass_cnt++;
    tick();
    total_cnt++; if (count !== 3'd0) $display("FAIL empty_ready_count got %0d exp 0", count); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      validi = 1'b1; data_in = 32'(i);
      tick();
    end
    validi = 1'b0;
    total_cnt++; if (count !== 3'd4) $display("FAIL ovf_count got %0d exp 4", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b exp 1", overflow); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total_cnt++;
      if (valido !== 1'b1 || data_out !== 32'(i))
        $display("FAIL ovf_drain_%0d got v=%0b d=%0d exp v=1 d=%0d", i, valido, data_out, i);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (valido !== 1'b0) $display("FAIL ovf_drain_end got %0b exp 0", valido); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0b exp 1", overflow); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_q [4] = '{32'd2, 32'd3, 32'd4, 32'd9};
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      validi = 1'b1; data_in = 32'(i);
      tick();
    end
    data_in = 32'd9; out_ready = 1'b1;
    total_cnt++; if (data_out !== 32'd1) $display("FAIL fpp_head got %0d exp 1", data_out); else pass_cnt++;
    tick();
    validi = 1'b0;
    total_cnt++; if (count !== 3'd4) $display("FAIL fpp_count got %0d exp 4", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL fpp_overflow got %0b exp 0", overflow); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (valido !== 1'b1 || data_out !== exp_q[i])
        $display("FAIL fpp_drain_%0d got v=%0b d=%0d exp v=1 d=%0d", i, valido, data_out, exp_q[i]);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (valido !== 1'b0) $display("FAIL fpp_end got %0b exp 0", valido); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    int errs = 0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      validi = 1'b1; data_in = 32'(100 + i);
      tick();
      if (valido !== 1'b1 || data_out !== 32'(100 + i) || count !== 3'd1) begin
        $display("FAIL wrap_%0d got v=%0b d=%0d c=%0d exp v=1 d=%0d c=1", i, valido, data_out, count, 100 + i);
        errs++;
      end
    end
    validi = 1'b0;
    total_cnt++; if (errs != 0) $display("FAIL wrap_stream got %0d errors exp 0", errs); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 3'd0) $display("FAIL wrap_final_count got %0d exp 0", count); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      validi = 1'b1; data_in = 32'(i);
      tick();
    end
    total_cnt++; if (overflow !== 1'b1) $display("FAIL mid_pre_overflow got %0b exp 1", overflow); else pass_cnt++;
    rst = 1'b1; validi = 1'b1; data_in = 32'd77; out_ready = 1'b1;
    tick();
    rst = 1'b0; validi = 1'b0;
    total_cnt++; if (count !== 3'd0) $display("FAIL mid_count got %0d exp 0", count); else pass_cnt++;
    total_cnt++; if (valido !== 1'b0) $display("FAIL mid_valido got %0b exp 0", valido); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_overflow got %0b exp 0", overflow); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL mid_drop_cnt got %0d exp 0", drop_cnt); else pass_cnt++;
    tick();
    total_cnt++; if (valido !== 1'b0) $display("FAIL mid_word_not_stored got %0b exp 0", valido); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      validi = 1'b1; data_in = 32'(i);
      tick();
      if (i == 6) begin
        total_cnt++; if (s_drop_cnt !== 2'd2) $display("FAIL sat_pre got %0d exp 2", s_drop_cnt); else pass_cnt++;
      end
    end
    validi = 1'b0;
    total_cnt++; if (s_drop_cnt !== 2'd3) $display("FAIL sat_drop_cnt got %0d exp 3", s_drop_cnt); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd5) $display("FAIL sat_wide_drop_cnt got %0d exp 5", drop_cnt); else pass_cnt++;
    total_cnt++; if (s_count !== 3'd4) $display("FAIL sat_count got %0d exp 4", s_count); else pass_cnt++;
    total_cnt++; if (s_overflow !== 1'b1) $display("FAIL sat_overflow got %0b exp 1", s_overflow); else pass_cnt++;
    total_cnt++; if (s_data_out !== 32'd1) $display("FAIL sat_head got %0d exp 1", s_data_out); else pass_cnt++;
    total_cnt++; if (s_valido !== 1'b1) $display("FAIL sat_valido got %0b exp 1", s_valido); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; validi = 1'b0; out_ready = 1'b0; data_in = '0;
    @(negedge clk);
    test_reset();
    test_latency_order();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_mid_reset();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
